lcd_frame_tx: RTL and testbench
===============================

# lcd_frame_tx

Downstream stage of the menu controller: drives an HD44780-compatible character LCD over an 8-bit parallel bus. It runs the power-on init, then on each `begin_tx` request writes two 16-character lines fetched from a string ROM by `index1`/`index2` and parks the blinking cursor at `cursor_pos`. It returns `lcd_done`, which the menu controller uses to gate button-driven transitions.

## Interface

- `PWR_CYC`, default 750_000: power-up wait in clocks (15 ms at 50 MHz).
- `CMD_CYC`, default 2_500: post-write wait for normal commands and data (50 µs).
- `CLR_CYC`, default 100_000: post-write wait after clear-display 0x01 (2 ms).
- `E_CYC`, default 25: `lcd_en` high time in clocks (0.5 µs).
- `clk` in 1: system clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `begin_tx` in 1: level request, held by the menu controller while a menu state is displayed.
- `index1` in 5: ROM entry for line 1 (DDRAM 0x00).
- `index2` in 5: ROM entry for line 2 (DDRAM 0x40).
- `cursor_pos` in 8: final DDRAM address, 0x00 or 0x40. Bit 7 is ignored.
- `lcd_done` out 1: current request is on the glass; the controller may act on buttons.
- `lcd_data` out 8: LCD DB7..DB0.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: tied 0 (write-only).
- `lcd_en` out 1: LCD enable strobe.

## Operation

- **Reset values:** all outputs are 0, the state is PWR_WAIT, and `shown_valid` is 0.
- **States:**
  - PWR_WAIT: counts `PWR_CYC`, then goes to INIT.
  - INIT: writes 0x38, 0x38, 0x38, 0x0F, 0x06, 0x01 with RS=0, then goes to IDLE.
  - IDLE → ADDR1 (0x80) → LINE1 (16 chars, RS=1) → ADDR2 (0xC0) → LINE2 (16 chars) → CURS (0x80 | `cursor_pos[6:0]`) → IDLE.
- **Write engine**, one write per command or character:
  - SETUP: 1 cycle. `lcd_data` and `lcd_rs` are driven.
  - EN_HI: `E_CYC` cycles with `lcd_en`=1.
  - WAIT: `CMD_CYC` cycles with `lcd_en`=0, or `CLR_CYC` for 0x01.
  - `lcd_data` and `lcd_rs` are held stable from SETUP through the end of WAIT.
- **Request capture in IDLE:** if `begin_tx`=1 and (`shown_valid`=0 or {`index1`,`index2`,`cursor_pos`} ≠ `shown`), latch the triple into `req` and go to ADDR1. Otherwise stay in IDLE and issue no bus activity.
- **End of frame:** after the CURS write completes, set `shown` ← `req` and `shown_valid` ← 1.
- **`lcd_done`** = (state==IDLE) & `shown_valid` & !(`begin_tx` & triple ≠ `shown`). It is combinational, so it falls in the same cycle a new request appears.
- **Character index:** a 4-bit counter 0..15 within LINE1/LINE2. Wrap at 15 advances the state.
- **ROM:** 1-cycle read latency. Address {index, char_idx} is presented one cycle before SETUP.

## Timing

- Per write: 1 + `E_CYC` + `CMD_CYC` clocks (`CLR_CYC` for 0x01).
- Frame: 35 writes → 35·(1+`E_CYC`+`CMD_CYC`) clocks, plus 1 capture cycle, from request to `lcd_done`=1.
- Init: `PWR_CYC` + 5·(1+`E_CYC`+`CMD_CYC`) + (1+`E_CYC`+`CLR_CYC`).
- **Boundary conditions:**
  - `begin_tx` during PWR_WAIT or INIT: ignored. It is served on the first IDLE cycle because it is a held level.
  - Inputs change mid-frame: the latched `req` is used and the frame completes. The mismatch then triggers an immediate rewrite on return to IDLE.
  - `begin_tx`=0 in IDLE: no write, regardless of input values.
  - `reset_n` low at any point: outputs go to 0 asynchronously, `shown_valid` clears, and the full init reruns.
  - `index` = 31: the blank entry, valid like any other.

## Structure

- **Package `lcd_pkg`:** command constants (FUNC_SET 0x38, DISP_ON 0x0F, ENTRY 0x06, CLEAR 0x01, SET_DDRAM 0x80, LINE2 0x40), the state enum, and a 32×16 byte string table. Entry 31 is 16 spaces.
- **Sub-module `lcd_string_rom`:** registered read, takes `index`[4:0] and `char_idx`[3:0] and returns `char`[7:0].
- **Top level:** sequencer, write-engine counters, and the `req`/`shown` registers.

## Test plan

Bench parameters: `PWR_CYC`=20, `CMD_CYC`=4, `CLR_CYC`=8, `E_CYC`=2.

1. **Init:** release `reset_n` with `begin_tx`=0 → after 20 cycles, 6 `lcd_en` pulses (2 cycles each) with RS=0 and data 38, 38, 38, 0F, 06, 01. The last wait is 8 cycles. `lcd_done`=0 throughout.
2. **First frame:** `begin_tx`=1, `index1`=0, `index2`=1, `cursor_pos`=0x40 → 35 pulses: 0x80, 16 chars matching ROM[0], 0xC0, 16 chars matching ROM[1], 0xC0. `lcd_done` rises 1 + 35·7 clocks after the request is captured.
3. **Held request:** keep the same triple with `begin_tx`=1 for 500 cycles → zero `lcd_en` pulses, `lcd_done` stays 1.
4. **Mid-frame change:** switch `index1` to 2 during LINE1 → the frame completes with ROM[0], `lcd_done` stays 0, then a second frame with ROM[2] follows and `lcd_done` goes 1.
5. **Reset mid-frame:** pulse `reset_n` low during LINE2 → `lcd_en`, `lcd_data`, `lcd_rs` and `lcd_done` are 0 in the same cycle. Init reruns, then the held request is rewritten in full.
6. **New triple without request:** new triple with `begin_tx`=0 → no bus activity, `lcd_done`=1. Raising `begin_tx` drops `lcd_done` in the same cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 frame transmitter: command bytes,
// sequencer/write-engine encodings, the request triple and the menu string table.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0F;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] SET_DDRAM = 8'h80;
    localparam logic [7:0] LINE2     = 8'h40;

    localparam int INIT_LEN = 6;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2,
        ST_CURS
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN_HI,
        PH_WAIT
    } wr_phase_t;

    typedef struct packed {
        logic [4:0] index1;
        logic [4:0] index2;
        logic [7:0] cursor_pos;
    } lcd_req_t;

    // 32 entries of exactly 16 characters; entry 31 is the blank line.
    localparam logic [127:0] STR_TABLE [32] = '{
        "MAIN MENU       ",
        "SET TIME        ",
        "SET ALARM       ",
        "BRIGHTNESS      ",
        "CONTRAST        ",
        "VOLUME          ",
        "LANGUAGE        ",
        "ABOUT           ",
        "HOURS: 00-23    ",
        "MINUTES: 00-59  ",
        "ALARM ON        ",
        "ALARM OFF       ",
        "SAVED           ",
        "CANCELLED       ",
        "ERROR           ",
        "PLEASE WAIT...  ",
        "LEVEL 1         ",
        "LEVEL 2         ",
        "LEVEL 3         ",
        "LEVEL 4         ",
        "ENGLISH         ",
        "DEUTSCH         ",
        "FRANCAIS        ",
        "ESPANOL         ",
        "FW VER 1.0      ",
        "HW REV B        ",
        "< BACK          ",
        "> NEXT          ",
        "[ OK ]          ",
        "0123456789ABCDEF",
        "abcdefghijklmnop",
        "                "
    };

    // Power-on command sequence: function set three times, display on, entry mode, clear.
    function automatic logic [7:0] init_cmd(input logic [3:0] step);
        case (step)
            4'd0, 4'd1, 4'd2: init_cmd = FUNC_SET;
            4'd3:             init_cmd = DISP_ON;
            4'd4:             init_cmd = ENTRY;
            default:          init_cmd = CLEAR;
        endcase
    endfunction

    // Character 0 of a string literal sits in the most significant byte.
    function automatic logic [7:0] str_char(input logic [4:0] index, input logic [3:0] char_idx);
        logic [127:0] s;
        s = STR_TABLE[index];
        str_char = s[{~char_idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_frame_tx_rom.sv
// Menu string ROM with a single registered read port.
module lcd_string_rom
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic [4:0] index,
    input  logic [3:0] char_idx,
    output logic [7:0] char
);

    // One-cycle read latency; contents are constant so no reset is needed.
    always_ff @(posedge clk) begin
        char <= str_char(index, char_idx);
    end

endmodule

// File: rtl/lcd_frame_tx.sv
// HD44780 8-bit bus driver: power-on init, then two 16-character lines plus a
// cursor placement per new request; lcd_done tells the menu controller the
// requested screen is on the glass.
module lcd_frame_tx
    import lcd_pkg::*;
#(
    parameter int PWR_CYC = 750_000,
    parameter int CMD_CYC = 2_500,
    parameter int CLR_CYC = 100_000,
    parameter int E_CYC   = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       begin_tx,
    input  logic [4:0] index1,
    input  logic [4:0] index2,
    input  logic [7:0] cursor_pos,
    output logic       lcd_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam int MAX_A   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int MAX_B   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(E_CYC - 1);

    lcd_state_t       state;
    wr_phase_t        phase;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       char_idx;
    logic             shown_valid;
    lcd_req_t         req;
    lcd_req_t         shown;
    lcd_req_t         triple;

    logic             req_new;
    logic             capture;
    logic             frame_end;
    logic [CNT_W-1:0] wait_last;

    lcd_state_t       nxt_state;
    logic [3:0]       nxt_idx;
    logic [7:0]       nxt_data;
    logic             nxt_rs;

    logic [4:0]       rom_index;
    logic [3:0]       rom_char_idx;
    logic [7:0]       rom_char;

    assign triple    = {index1, index2, cursor_pos};
    assign req_new   = begin_tx && (!shown_valid || (triple != shown));
    assign capture   = (state == ST_IDLE) && req_new;
    assign wait_last = (!lcd_rs && (lcd_data == CLEAR)) ? CLR_LAST : CMD_LAST;
    assign frame_end = (state == ST_CURS) && (phase == PH_WAIT) && (cnt == wait_last);
    assign lcd_done  = (state == ST_IDLE) && shown_valid && !(begin_tx && (triple != shown));
    assign lcd_rw    = 1'b0;

    // The ROM always looks one character ahead so its registered output is
    // settled by the time the next write's SETUP loads it onto the bus.
    assign rom_index    = ((state == ST_ADDR1) || (state == ST_LINE1)) ? req.index1 : req.index2;
    assign rom_char_idx = ((state == ST_LINE1) || (state == ST_LINE2)) ? char_idx + 4'd1 : 4'd0;

    lcd_string_rom u_rom (
        .clk      (clk),
        .index    (rom_index),
        .char_idx (rom_char_idx),
        .char     (rom_char)
    );

    // Decide the sequencer step and bus value that follow the current write.
    always_comb begin
        nxt_state = state;
        nxt_idx   = char_idx;
        nxt_data  = lcd_data;
        nxt_rs    = lcd_rs;
        case (state)
            ST_INIT: begin
                if (char_idx == 4'(INIT_LEN - 1)) begin
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_idx  = char_idx + 4'd1;
                    nxt_data = init_cmd(char_idx + 4'd1);
                    nxt_rs   = 1'b0;
                end
            end
            ST_ADDR1: begin
                nxt_state = ST_LINE1;
                nxt_idx   = 4'd0;
                nxt_data  = rom_char;
                nxt_rs    = 1'b1;
            end
            ST_LINE1: begin
                if (char_idx == 4'd15) begin
                    nxt_state = ST_ADDR2;
                    nxt_data  = SET_DDRAM | LINE2;
                    nxt_rs    = 1'b0;
                end else begin
                    nxt_idx  = char_idx + 4'd1;
                    nxt_data = rom_char;
                    nxt_rs   = 1'b1;
                end
            end
            ST_ADDR2: begin
                nxt_state = ST_LINE2;
                nxt_idx   = 4'd0;
                nxt_data  = rom_char;
                nxt_rs    = 1'b1;
            end
            ST_LINE2: begin
                if (char_idx == 4'd15) begin
                    nxt_state = ST_CURS;
                    nxt_data  = SET_DDRAM | {1'b0, req.cursor_pos[6:0]};
                    nxt_rs    = 1'b0;
                end else begin
                    nxt_idx  = char_idx + 4'd1;
                    nxt_data = rom_char;
                    nxt_rs   = 1'b1;
                end
            end
            ST_CURS: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = state;
            end
        endcase
    end

    // Sequencer and write engine: SETUP (1) -> EN_HI (E_CYC) -> WAIT (CMD/CLR).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PWR_WAIT;
            phase       <= PH_SETUP;
            cnt         <= '0;
            char_idx    <= '0;
            shown_valid <= 1'b0;
            lcd_data    <= '0;
            lcd_rs      <= 1'b0;
            lcd_en      <= 1'b0;
        end else begin
            case (state)
                ST_PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        state    <= ST_INIT;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                        char_idx <= '0;
                        lcd_data <= init_cmd(4'd0);
                        lcd_rs   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (capture) begin
                        state    <= ST_ADDR1;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                        lcd_data <= SET_DDRAM;
                        lcd_rs   <= 1'b0;
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            phase  <= PH_EN_HI;
                            lcd_en <= 1'b1;
                            cnt    <= '0;
                        end
                        PH_EN_HI: begin
                            if (cnt == E_LAST) begin
                                phase  <= PH_WAIT;
                                lcd_en <= 1'b0;
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt == wait_last) begin
                                state    <= nxt_state;
                                char_idx <= nxt_idx;
                                phase    <= PH_SETUP;
                                cnt      <= '0;
                                lcd_data <= nxt_data;
                                lcd_rs   <= nxt_rs;
                                if (frame_end) begin
                                    shown_valid <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // Request snapshot and last-displayed triple; shown_valid qualifies shown.
    always_ff @(posedge clk) begin
        if (capture) begin
            req <= triple;
        end
        if (frame_end) begin
            shown <= req;
        end
    end

endmodule

// File: tb/tb_lcd_frame_tx.sv
// Randomized self-checking bench for lcd_frame_tx with short timing parameters.
module tb_lcd_frame_tx;

    localparam int PWR = 20;
    localparam int CMD = 4;
    localparam int CLR = 8;
    localparam int EC  = 2;
    localparam int WR  = 1 + EC + CMD;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       begin_tx;
    logic [4:0] index1;
    logic [4:0] index2;
    logic [7:0] cursor_pos;
    logic       lcd_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    lcd_frame_tx #(.PWR_CYC(PWR), .CMD_CYC(CMD), .CLR_CYC(CLR), .E_CYC(EC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .begin_tx   (begin_tx),
        .index1     (index1),
        .index2     (index2),
        .cursor_pos (cursor_pos),
        .lcd_done   (lcd_done),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    string tbl [32] = '{
        "MAIN MENU       ", "SET TIME        ", "SET ALARM       ", "BRIGHTNESS      ",
        "CONTRAST        ", "VOLUME          ", "LANGUAGE        ", "ABOUT           ",
        "HOURS: 00-23    ", "MINUTES: 00-59  ", "ALARM ON        ", "ALARM OFF       ",
        "SAVED           ", "CANCELLED       ", "ERROR           ", "PLEASE WAIT...  ",
        "LEVEL 1         ", "LEVEL 2         ", "LEVEL 3         ", "LEVEL 4         ",
        "ENGLISH         ", "DEUTSCH         ", "FRANCAIS        ", "ESPANOL         ",
        "FW VER 1.0      ", "HW REV B        ", "< BACK          ", "> NEXT          ",
        "[ OK ]          ", "0123456789ABCDEF", "abcdefghijklmnop", "                "
    };

    typedef struct {
        int         cyc;
        logic [8:0] w;
    } pulse_t;

    pulse_t     pulses [$];
    logic [8:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: records every enable pulse and its {rs,data}, checks width and stability.
    logic       en_prev = 1'b0;
    logic       done_prev = 1'b0;
    int         en_w = 0;
    logic [8:0] rise_w = '0;
    int         done_hi = 0;
    int         done_rise_cyc = -1;

    always @(negedge clk) begin
        if (lcd_done) done_hi++;
        if (lcd_done && !done_prev) done_rise_cyc = cyc;
        done_prev = lcd_done;
        if (lcd_en && !en_prev) begin
            pulses.push_back('{cyc, {lcd_rs, lcd_data}});
            en_w   = 1;
            rise_w = {lcd_rs, lcd_data};
        end else if (lcd_en) begin
            en_w++;
        end else if (en_prev && reset_n) begin
            check_eq("en_width", en_w, EC);
            check_eq("bus_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, rise_w});
        end
        en_prev = lcd_en;
    end

    function automatic logic [7:0] chr(input int i, input int k);
        string s;
        s = tbl[i];
        return s[k];
    endfunction

    function automatic void push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0F});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endfunction

    function automatic void push_frame(input int i1, input int i2, input logic [7:0] cur);
        exp_q.push_back({1'b0, 8'h80});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, chr(i1, k)});
        exp_q.push_back({1'b0, 8'hC0});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, chr(i2, k)});
        exp_q.push_back({1'b0, 8'h80 | {1'b0, cur[6:0]}});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for all expected writes, then compare them in order.
    task automatic consume(input string tag, output int first_cyc, output int last_cyc);
        int     n;
        int     k;
        pulse_t p;
        logic [8:0] e;
        n = exp_q.size();
        k = 0;
        first_cyc = -1;
        last_cyc  = -1;
        while (pulses.size() < n && k < n * 12 + 100) begin
            @(negedge clk);
            k++;
        end
        if (pulses.size() < n) check_eq({tag, "_timeout"}, pulses.size(), n);
        for (int j = 0; j < n && pulses.size() > 0; j++) begin
            p = pulses.pop_front();
            e = exp_q[j];
            check_eq($sformatf("%s[%0d]", tag, j), {23'd0, p.w}, {23'd0, e});
            if (j == 0) first_cyc = p.cyc;
            last_cyc = p.cyc;
        end
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!lcd_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!lcd_done) check_eq({tag, "_done_timeout"}, lcd_done, 1'b1);
        tick(1);
    endtask

    logic [17:0] shown_m;
    bit          valid_m;

    initial begin
        int rel, c0, f, l, fa, la, d0, bad;
        logic [17:0] trip;

        reset_n = 1'b0; begin_tx = 1'b0;
        index1 = '0; index2 = '0; cursor_pos = '0;
        valid_m = 1'b0; shown_m = '0;
        tick(3);
        check_eq("rst_en",   lcd_en,   1'b0);
        check_eq("rst_data", lcd_data, 8'h00);
        check_eq("rst_rs",   lcd_rs,   1'b0);
        check_eq("rst_rw",   lcd_rw,   1'b0);
        check_eq("rst_done", lcd_done, 1'b0);

        // Power-on init with no request pending.
        reset_n = 1'b1;
        rel = cyc;
        push_init();
        consume("init", f, l);
        check_eq("init_start", f, rel + PWR + 1);
        check_eq("init_span", l - f, 5 * WR);
        tick(EC + CLR + 4);
        check_eq("init_quiet", pulses.size(), 0);
        check_eq("init_done_low", done_hi, 0);

        // First frame.
        index1 = 5'd0; index2 = 5'd1; cursor_pos = 8'h40; begin_tx = 1'b1;
        c0 = cyc;
        push_frame(0, 1, 8'h40);
        consume("frame1", f, l);
        check_eq("frame1_start", f, c0 + 2);
        check_eq("frame1_span", l - f, 34 * WR);
        wait_done("frame1");
        check_eq("frame1_done_cyc", done_rise_cyc, c0 + 1 + 35 * WR);
        shown_m = {5'd0, 5'd1, 8'h40}; valid_m = 1'b1;

        // Held request: nothing new to draw.
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!lcd_done) bad++;
        end
        check_eq("held_done_low_cycles", bad, 0);
        check_eq("held_pulses", pulses.size(), 0);

        // Inputs change during LINE1: old frame completes, then rewrite.
        cursor_pos = 8'h00;
        begin_tx   = 1'b1;
        while (pulses.size() < 5) @(negedge clk);
        d0 = done_hi;
        index1 = 5'd2;
        push_frame(0, 1, 8'h00);
        consume("midA", fa, la);
        push_frame(2, 1, 8'h00);
        consume("midB", f, l);
        check_eq("mid_gap", f - la, EC + CMD + 2);
        check_eq("mid_done_low", done_hi - d0, 0);
        wait_done("midB");
        check_eq("mid_done_high", lcd_done, 1'b1);
        shown_m = {5'd2, 5'd1, 8'h00};

        // Randomized requests against the shown-triple model.
        for (int it = 0; it < 6; it++) begin
            if (it != 3) begin
                index1     = 5'($urandom_range(0, 31));
                index2     = 5'($urandom_range(0, 31));
                cursor_pos = {1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 7'h40 : 7'h00};
            end
            trip = {index1, index2, cursor_pos};
            begin_tx = 1'b1;
            c0 = cyc;
            if (!valid_m || trip != shown_m) begin
                push_frame(int'(index1), int'(index2), cursor_pos);
                consume("rand", f, l);
                wait_done("rand");
                check_eq("rand_done_cyc", done_rise_cyc, c0 + 1 + 35 * WR);
                shown_m = trip; valid_m = 1'b1;
            end else begin
                tick(40);
                check_eq("rand_same_pulses", pulses.size(), 0);
                check_eq("rand_same_done", lcd_done, 1'b1);
            end
        end

        // Reset during LINE2: outputs clear at once, init reruns, request redrawn.
        index1 = 5'd5; index2 = 5'd6; cursor_pos = 8'h40; begin_tx = 1'b1;
        while (pulses.size() < 20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_en",   lcd_en,   1'b0);
        check_eq("arst_data", lcd_data, 8'h00);
        check_eq("arst_rs",   lcd_rs,   1'b0);
        check_eq("arst_done", lcd_done, 1'b0);
        pulses.delete();
        exp_q.delete();
        valid_m = 1'b0;
        tick(3);
        reset_n = 1'b1;
        rel = cyc;
        push_init();
        consume("reinit", f, l);
        check_eq("reinit_start", f, rel + PWR + 1);
        push_frame(5, 6, 8'h40);
        consume("reframe", fa, la);
        check_eq("reframe_gap", fa - l, EC + CLR + 2);
        wait_done("reframe");
        check_eq("reframe_done", lcd_done, 1'b1);
        shown_m = {5'd5, 5'd6, 8'h40}; valid_m = 1'b1;

        // New triple without a request, then raise the request (blank entry 31).
        begin_tx = 1'b0; index1 = 5'd31; index2 = 5'd31; cursor_pos = 8'h00;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!lcd_done) bad++;
        end
        check_eq("noreq_done_low_cycles", bad, 0);
        check_eq("noreq_pulses", pulses.size(), 0);
        begin_tx = 1'b1;
        #1;
        check_eq("done_drop", lcd_done, 1'b0);
        c0 = cyc;
        push_frame(31, 31, 8'h00);
        consume("blank", f, l);
        wait_done("blank");
        check_eq("blank_done_cyc", done_rise_cyc, c0 + 1 + 35 * WR);
        check_eq("final_rw", lcd_rw, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
